fifo_write_arbiter: RTL
=======================

FIFO_WRITE_ARBITER -- requirements
Module: fifo_write_arbiter

Interface
REQ-001 Parameters SHALL be: N_REQ, default 4, number of requesters; DATA_SIZE, default 4, FIFO word width; BURST_MAX, default 4, maximum beats per grant.
REQ-002 clk_write  input  1  write-domain clock; all state updates on its rising edge.
REQ-003 reset  input  1  reset, synchronous, active-high; clock clk_write.
REQ-004 req  input  N_REQ  per-requester write request; bit i belongs to requester i.
REQ-005 req_data  input  N_REQ*DATA_SIZE  requester i word at bits [i*DATA_SIZE +: DATA_SIZE]; held stable while req[i] is high and ack[i] is low.
REQ-006 fifo_full  input  1  full flag from the FIFO write side.
REQ-007 ack  output  N_REQ  one-hot or zero; ack[i] high means requester i's word is written this cycle.
REQ-008 fifo_write_mode  output  1  FIFO write strobe.
REQ-009 fifo_data_in  output  DATA_SIZE  word presented to the FIFO.
REQ-010 grant_id  output  clog2(N_REQ)  index of current grant holder; registered.
REQ-011 busy  output  1  high in GRANT state.
REQ-012 beat_count  output  16  total accepted writes since reset; wraps at 65535 -> 0.

Function
REQ-013 FSM SHALL have two states: IDLE and GRANT.
REQ-014 IDLE: if any req bit is high, next state GRANT; grant_id <= first requester with req high, searching round-robin from rr_ptr upward with wrap; otherwise stay IDLE.
REQ-015 Arbitration SHALL ignore fifo_full; a full FIFO stalls the grant holder in GRANT.
REQ-016 On each grant, rr_ptr SHALL become (granted index + 1) mod N_REQ.
REQ-017 Beat condition: state==GRANT && req[grant_id] && !fifo_full && !reset.
REQ-018 fifo_write_mode and ack[grant_id] SHALL equal the beat condition combinationally; all other ack bits are 0.
REQ-019 fifo_data_in SHALL be the req_data slice selected by grant_id; its value is don't-care when there is no beat.
REQ-020 Each beat SHALL increment burst_cnt and beat_count.
REQ-021 GRANT -> IDLE when a beat occurs with burst_cnt == BURST_MAX-1; burst_cnt <= 0.
REQ-022 GRANT -> IDLE when req[grant_id] is low; no beat occurs that cycle; burst_cnt <= 0.
REQ-023 While fifo_full is high in GRANT: no beat; burst_cnt and state hold; no timeout.
REQ-024 A release costs exactly one IDLE cycle before the next grant; no back-to-back regrant in the same cycle.
REQ-025 Requests from non-holders during GRANT SHALL be ignored until the next IDLE.

Reset
REQ-026 On reset: state=IDLE, grant_id=0, rr_ptr=0, burst_cnt=0, beat_count=0, busy=0.
REQ-027 During reset, fifo_write_mode=0 and ack=0; the same holds for reset asserted mid-burst.
REQ-028 The first arbitration after reset SHALL favour requester 0.

Structure
REQ-029 Shared package fifo_arb_pkg SHALL hold the state encoding (IDLE=0, GRANT=1) and the default N_REQ, DATA_SIZE and BURST_MAX.
REQ-030 A single combinational sub-module rr_pick SHALL take req and rr_ptr and return found plus index; all other logic stays in fifo_write_arbiter.

Verification
REQ-031 Test 1: req=0001 held, data 0x3, 0x5, 0x7, 0x9, 0xB, fifo_full=0 -> 4 beats on consecutive cycles, 1 IDLE cycle, then 1 more beat; beat_count=5.
REQ-032 Test 2: req=1111 held continuously -> grant_id sequence 0,1,2,3,0; each grant gives exactly 4 acks.
REQ-033 Test 3: requester 2 granted, fifo_full high for 3 cycles after beat 2 -> no acks for 3 cycles, then beats 3 and 4, then release; no data lost or duplicated.
REQ-034 Test 4: req[1] dropped after 2 beats -> IDLE the next cycle with burst_cnt=0; req[3] pending -> grant_id=3 one cycle later.
REQ-035 Test 5: reset asserted mid-burst on the 3rd beat cycle -> that cycle's fifo_write_mode=0 and ack=0; afterwards state=IDLE, beat_count=0, first grant goes to requester 0 when req=1111.
REQ-036 Test 6: 65536 beats -> beat_count wraps to 0; scoreboard confirms the FIFO write stream equals the acked words in order.

Source files
------------

// File: rtl/fifo_arb_pkg.sv
// fifo_arb_pkg: shared types and defaults for the FIFO write arbiter.
// Holds the FSM state encoding and default sizing parameters.
package fifo_arb_pkg;

    localparam int N_REQ_DEF     = 4;
    localparam int DATA_SIZE_DEF = 4;
    localparam int BURST_MAX_DEF = 4;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_t;

    // Width of a burst counter able to hold 0..n.
    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n + 1) : 1;
    endfunction

endpackage

// File: rtl/fifo_write_arbiter_if.sv
// fifo_write_arbiter_if: requester + FIFO write-side bundle.
// master: req, req_data, fifo_full out / ack, fifo_write_mode, fifo_data_in in.
// slave : the arbiter's view (directions reversed).
interface fifo_write_arbiter_if
    import fifo_arb_pkg::*;
#(
    parameter int N_REQ     = N_REQ_DEF,
    parameter int DATA_SIZE = DATA_SIZE_DEF
);

    logic [N_REQ-1:0]           req;
    logic [N_REQ*DATA_SIZE-1:0] req_data;
    logic                       fifo_full;
    logic [N_REQ-1:0]           ack;
    logic                       fifo_write_mode;
    logic [DATA_SIZE-1:0]       fifo_data_in;

    modport master (
        output req,
        output req_data,
        output fifo_full,
        input  ack,
        input  fifo_write_mode,
        input  fifo_data_in
    );

    modport slave (
        input  req,
        input  req_data,
        input  fifo_full,
        output ack,
        output fifo_write_mode,
        output fifo_data_in
    );

endinterface

// File: rtl/fifo_write_arbiter_rr_pick.sv
// rr_pick: combinational round-robin search over req starting at ptr.
// Ports: req, ptr in; found (any req set), idx (first set bit from ptr, wrapping).
module rr_pick #(
    parameter int N = 4,
    parameter int W = 2
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] ptr,
    output logic         found,
    output logic [W-1:0] idx
);

    always_comb begin
        int c;
        found = 1'b0;
        idx   = '0;
        c     = 0;
        for (int i = 0; i < N; i++) begin
            c = int'(ptr) + i;
            if (c >= N) begin
                c = c - N;
            end
            if (!found && req[c]) begin
                found = 1'b1;
                idx   = W'(c);
            end
        end
    end

endmodule

// File: rtl/fifo_write_arbiter.sv
// fifo_write_arbiter: round-robin arbiter granting bursts of FIFO writes.
// Ports: clk_write, reset (sync, active-high), bus (slave: req/req_data/
// fifo_full in, ack/fifo_write_mode/fifo_data_in out), grant_id, busy,
// beat_count (16-bit wrapping count of accepted writes).
module fifo_write_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int N_REQ     = N_REQ_DEF,
    parameter int DATA_SIZE = DATA_SIZE_DEF,
    parameter int BURST_MAX = BURST_MAX_DEF,
    localparam int GW       = $clog2(N_REQ)
) (
    input  logic                  clk_write,
    input  logic                  reset,
    fifo_write_arbiter_if.slave   bus,
    output logic [GW-1:0]         grant_id,
    output logic                  busy,
    output logic [15:0]           beat_count
);

    localparam int BW = cnt_w(BURST_MAX);

    arb_state_t    state;
    logic [GW-1:0] rr_ptr;
    logic [BW-1:0] burst_cnt;

    logic          pick_found;
    logic [GW-1:0] pick_idx;
    logic [GW-1:0] ptr_next;
    logic          holder_req;
    logic          beat;
    logic          last_beat;

    rr_pick #(
        .N (N_REQ),
        .W (GW)
    ) u_rr_pick (
        .req   (bus.req),
        .ptr   (rr_ptr),
        .found (pick_found),
        .idx   (pick_idx)
    );

    assign ptr_next   = (pick_idx == GW'(N_REQ - 1)) ? '0 : pick_idx + 1'b1;
    assign holder_req = bus.req[grant_id];
    assign last_beat  = (burst_cnt == BW'(BURST_MAX - 1));

    // Gating with reset keeps the strobe quiet even if reset lands mid-burst.
    assign beat = (state == GRANT) && holder_req && !bus.fifo_full && !reset;

    always_comb begin
        bus.ack           = '0;
        bus.ack[grant_id] = beat;
    end

    assign bus.fifo_write_mode = beat;
    assign bus.fifo_data_in    =
        bus.req_data[int'(grant_id)*DATA_SIZE +: DATA_SIZE];
    assign busy = (state == GRANT);

    always_ff @(posedge clk_write) begin
        if (reset) begin
            state      <= IDLE;
            grant_id   <= '0;
            rr_ptr     <= '0;
            burst_cnt  <= '0;
            beat_count <= '0;
        end else begin
            if (beat) begin
                beat_count <= beat_count + 16'd1;
            end
            unique case (state)
                IDLE: begin
                    if (pick_found) begin
                        state    <= GRANT;
                        grant_id <= pick_idx;
                        rr_ptr   <= ptr_next;
                    end
                end
                GRANT: begin
                    // A stalled holder (fifo_full) simply waits here.
                    if (!holder_req) begin
                        state     <= IDLE;
                        burst_cnt <= '0;
                    end else if (beat) begin
                        if (last_beat) begin
                            state     <= IDLE;
                            burst_cnt <= '0;
                        end else begin
                            burst_cnt <= burst_cnt + 1'b1;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
